// File: rtl/tdc_data_tx_if.sv
// Word handshake between a TDC hit source and the tdc_data_tx serializer.
interface tdc_data_tx_if;
  logic [31:0] DATA_IN;
  logic        DATA_VALID;
  logic        DATA_READY;

  modport master (output DATA_IN, output DATA_VALID, input DATA_READY);
  modport slave  (input DATA_IN, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/tdc_data_tx.sv
// Buffers 32-bit hit words in a small FIFO and sends each one as a framed,
// odd-parity serial frame on DATA_OUT (start, 32 data MSB first, parity, stop).
module tdc_data_tx #(
  parameter int CLK_DIV    = 10,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RESETB,
  input  logic                        ENABLE,
  tdc_data_tx_if.slave                hit,
  output logic                        DATA_OUT,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [31:0] word);
    return ~^word;
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    timer_r, timer_s;
  logic [4:0]    bit_r, bit_s;
  logic [1:0]    stop_r, stop_s;
  logic [31:0]   shift_r, shift_s;
  logic          parity_r, parity_s;
  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_s;
  logic          ready_r, data_out_r, busy_r;
  logic          push_s, pop_s, bit_end_s, start_ok_s, line_s, busy_s;
  logic [31:0]   head_s;

  // Next-state, bit timing, FIFO accounting and line level
  always_comb begin
    push_s     = hit.DATA_VALID & ready_r;
    head_s     = mem_r[rd_ptr_r];
    bit_end_s  = (timer_r == 8'(CLK_DIV - 1));
    start_ok_s = ENABLE & (count_r != CW'(0));
    state_s    = state_r;
    timer_s    = bit_end_s ? 8'd0 : timer_r + 8'd1;
    bit_s      = bit_r;
    stop_s     = stop_r;
    shift_s    = shift_r;
    parity_s   = parity_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        timer_s = 8'd0;
        if (start_ok_s) begin
          pop_s    = 1'b1;
          state_s  = START;
          shift_s  = head_s;
          parity_s = odd_parity(head_s);
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          bit_s   = 5'd31;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          if (bit_r == 5'd0) begin
            state_s = PARITY;
          end else begin
            shift_s = {shift_r[30:0], 1'b0};
            bit_s   = bit_r - 5'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          stop_s  = 2'd0;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (stop_r == 2'(STOP_BITS - 1)) begin
            // Back-to-back frames: the next start bit follows the last stop bit directly
            if (start_ok_s) begin
              pop_s    = 1'b1;
              state_s  = START;
              shift_s  = head_s;
              parity_s = odd_parity(head_s);
            end else begin
              state_s = IDLE;
            end
          end else begin
            stop_s = stop_r + 2'd1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = 8'd0;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase

    case (state_r)
      IDLE:    line_s = 1'b1;
      START:   line_s = 1'b0;
      DATA:    line_s = shift_r[31];
      PARITY:  line_s = parity_r;
      STOP:    line_s = 1'b1;
      default: line_s = 1'b1;
    endcase
    busy_s = (state_r != IDLE) | (count_r != CW'(0));
  end

  // Frame sequencer registers
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_r  <= IDLE;
      timer_r  <= 8'd0;
      bit_r    <= 5'd0;
      stop_r   <= 2'd0;
      shift_r  <= 32'd0;
      parity_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      bit_r    <= bit_s;
      stop_r   <= stop_s;
      shift_r  <= shift_s;
      parity_r <= parity_s;
    end
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      ready_r  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_s;
      ready_r <= (count_s != CW'(FIFO_DEPTH));
    end
  end

  // FIFO word storage
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 32'd0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= hit.DATA_IN;
    end
  end

  // Line and status outputs, registered so the line never glitches
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      data_out_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      data_out_r <= line_s;
      busy_r     <= busy_s;
    end
  end

  assign DATA_OUT       = data_out_r;
  assign BUSY           = busy_r;
  assign FIFO_COUNT     = count_r;
  assign hit.DATA_READY = ready_r;
endmodule

// File: tb/tb_tdc_data_tx.sv
// Directed bench for tdc_data_tx: one instance at CLK_DIV=4 and one at CLK_DIV=1.
module tb_tdc_data_tx;
  logic        clk;
  logic        rstn;
  logic        en4, en1;
  logic        dout4, busy4, dout1, busy1;
  logic [2:0]  cnt4, cnt1;
  int          pass_cnt;
  int          total_cnt;
  logic [31:0] q4[$];

  tdc_data_tx_if if4();
  tdc_data_tx_if if1();

  tdc_data_tx #(.CLK_DIV(4), .STOP_BITS(1), .FIFO_DEPTH(4)) dut4 (
    .CLK(clk), .RESETB(rstn), .ENABLE(en4), .hit(if4),
    .DATA_OUT(dout4), .BUSY(busy4), .FIFO_COUNT(cnt4)
  );

  tdc_data_tx #(.CLK_DIV(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .CLK(clk), .RESETB(rstn), .ENABLE(en1), .hit(if1),
    .DATA_OUT(dout1), .BUSY(busy1), .FIFO_COUNT(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents the head of the pending-word queue to dut4
  task automatic drive();
    if (q4.size() > 0) begin
      if4.DATA_IN    = q4[0];
      if4.DATA_VALID = 1'b1;
    end else begin
      if4.DATA_VALID = 1'b0;
    end
  endtask

  task automatic tick();
    logic acc;
    drive();
    acc = if4.DATA_VALID & if4.DATA_READY;
    @(posedge clk);
    #1;
    if (acc) void'(q4.pop_front());
    drive();
  endtask

  // Checks one whole frame cycle by cycle, starting at the first start-bit cycle
  task automatic check_frame(input int sel, input string tag, input logic [31:0] w,
                             input logic par, input int drop_at);
    int          div;
    int          errs;
    logic [34:0] fr;
    logic        obs;
    div  = (sel == 1) ? 1 : 4;
    fr   = {1'b0, w, par, 1'b1};
    errs = 0;
    for (int c = 0; c < 35 * div; c++) begin
      if (c == drop_at) en4 = 1'b0;
      obs = (sel == 1) ? dout1 : dout4;
      if (obs !== fr[34 - c / div]) errs++;
      if (((sel == 1) ? busy1 : busy4) !== 1'b1) errs++;
      tick();
    end
    chk(tag, errs, 0);
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rstn = 1'b0;
    en4 = 1'b0;
    en1 = 1'b1;
    if4.DATA_IN = 32'd0;
    if4.DATA_VALID = 1'b0;
    if1.DATA_IN = 32'd0;
    if1.DATA_VALID = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout4, 1'b1);
    chk("rst_ready", if4.DATA_READY, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_count", cnt4, 3'd0);
    chk("rst_dout1", dout1, 1'b1);
    #2 rstn = 1'b1;
    tick();
    chk("ready_after_rst", if4.DATA_READY, 1'b1);

    // Single word, CLK_DIV=4: start bit two edges after the push
    en4 = 1'b1;
    q4.push_back(32'hA5A5_0001);
    tick();
    chk("t1_count_push", cnt4, 3'd1);
    chk("t1_dout_push", dout4, 1'b1);
    tick();
    chk("t1_count_pop", cnt4, 3'd0);
    chk("t1_dout_pop", dout4, 1'b1);
    chk("t1_busy_pop", busy4, 1'b1);
    tick();
    check_frame(0, "t1_frame", 32'hA5A5_0001, 1'b0, -1);
    chk("t1_busy_end", busy4, 1'b0);
    chk("t1_dout_end", dout4, 1'b1);

    // Back-to-back words, CLK_DIV=1
    if1.DATA_IN = 32'h0000_0000;
    if1.DATA_VALID = 1'b1;
    tick();
    if1.DATA_IN = 32'hFFFF_FFFF;
    tick();
    if1.DATA_VALID = 1'b0;
    chk("t2_count", cnt1, 3'd1);
    chk("t2_dout_pop", dout1, 1'b1);
    tick();
    check_frame(1, "t2_frame0", 32'h0000_0000, 1'b1, -1);
    check_frame(1, "t2_frame1", 32'hFFFF_FFFF, 1'b1, -1);
    chk("t2_busy_end", busy1, 1'b0);
    chk("t2_dout_end", dout1, 1'b1);

    // Fill past capacity with ENABLE low, then drain
    en4 = 1'b0;
    q4.push_back(32'h0000_0001);
    q4.push_back(32'h0000_0003);
    q4.push_back(32'h8000_0000);
    q4.push_back(32'hF0F0_F0F0);
    q4.push_back(32'h1234_5678);
    q4.push_back(32'hDEAD_BEEF);
    repeat (6) tick();
    chk("t3_count_full", cnt4, 3'd4);
    chk("t3_ready_full", if4.DATA_READY, 1'b0);
    chk("t3_dout_full", dout4, 1'b1);
    chk("t3_busy_full", busy4, 1'b1);
    chk("t3_pending", q4.size(), 2);
    en4 = 1'b1;
    tick();
    chk("t4_count_pop_no_push", cnt4, 3'd3);
    chk("t4_ready_after_pop", if4.DATA_READY, 1'b1);
    chk("t4_dout_pop", dout4, 1'b1);
    tick();
    chk("t4_count_refill", cnt4, 3'd4);
    check_frame(0, "t3_w0", 32'h0000_0001, 1'b0, -1);
    check_frame(0, "t3_w1", 32'h0000_0003, 1'b1, -1);
    check_frame(0, "t3_w2", 32'h8000_0000, 1'b0, -1);
    check_frame(0, "t3_w3", 32'hF0F0_F0F0, 1'b1, -1);
    check_frame(0, "t3_w4", 32'h1234_5678, 1'b0, -1);
    check_frame(0, "t3_w5", 32'hDEAD_BEEF, 1'b1, -1);
    chk("t3_busy_end", busy4, 1'b0);
    chk("t3_count_end", cnt4, 3'd0);

    // ENABLE dropped at data bit 10 with two words queued
    en4 = 1'b1;
    q4.push_back(32'h0F0F_0F0F);
    q4.push_back(32'h0000_00FF);
    q4.push_back(32'h0000_0007);
    repeat (3) tick();
    chk("t5_count_start", cnt4, 3'd2);
    check_frame(0, "t5_frame", 32'h0F0F_0F0F, 1'b1, 44);
    chk("t5_dout_idle", dout4, 1'b1);
    chk("t5_count", cnt4, 3'd2);
    chk("t5_busy", busy4, 1'b1);
    repeat (8) tick();
    chk("t5_dout_hold", dout4, 1'b1);
    chk("t5_count_hold", cnt4, 3'd2);

    // Reset in the middle of a frame with three words queued
    q4.push_back(32'h0000_0011);
    tick();
    chk("t6_count3", cnt4, 3'd3);
    en4 = 1'b1;
    tick();
    q4.push_back(32'h0000_0022);
    tick();
    repeat (9) tick();
    chk("t6_dout_pre", dout4, 1'b0);
    chk("t6_count_pre", cnt4, 3'd3);
    #2 rstn = 1'b0;
    #1;
    chk("t6_dout_async", dout4, 1'b1);
    chk("t6_count_async", cnt4, 3'd0);
    chk("t6_busy_async", busy4, 1'b0);
    chk("t6_ready_async", if4.DATA_READY, 1'b0);
    q4.delete();
    if4.DATA_VALID = 1'b0;
    #2 rstn = 1'b1;
    tick();
    chk("t6_ready_rel", if4.DATA_READY, 1'b1);
    chk("t6_busy_rel", busy4, 1'b0);
    q4.push_back(32'h0000_0100);
    repeat (3) tick();
    check_frame(0, "t6_frame", 32'h0000_0100, 1'b0, -1);
    chk("t6_busy_end", busy4, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
